// File: rtl/irrigation_sequencer_if.sv
// Sensor and actuator bundle for irrigation_sequencer: the controller takes the
// slave side, the environment or bench drives the master side.
interface irrigation_sequencer_if #(
    parameter int ZONES = 4
);
    localparam int ZW = $clog2(ZONES);

    logic             low_water_level;
    logic             mid_water_level;
    logic             high_water_level;
    logic [ZONES-1:0] earth_humidity;
    logic             air_humidity;
    logic             low_temperature;

    logic             water_supply_valvule;
    logic             alarm;
    logic             splinker_bomb;
    logic             dripper_valvule;
    logic [ZONES-1:0] zone_valvule;
    logic [ZW-1:0]    active_zone;
    logic [1:0]       fault_code;

    modport slave (
        input  low_water_level, mid_water_level, high_water_level,
        input  earth_humidity, air_humidity, low_temperature,
        output water_supply_valvule, alarm, splinker_bomb, dripper_valvule,
        output zone_valvule, active_zone, fault_code
    );

    modport master (
        output low_water_level, mid_water_level, high_water_level,
        output earth_humidity, air_humidity, low_temperature,
        input  water_supply_valvule, alarm, splinker_bomb, dripper_valvule,
        input  zone_valvule, active_zone, fault_code
    );
endinterface

// File: rtl/irrigation_sequencer.sv
// Multi-zone round-robin irrigation sequencer with debounced sensors, tank refill
// hysteresis and fault reporting. Optional per-zone run limit: IRRIGATION_RUN_LIMIT_EN.
module irrigation_sequencer #(
    parameter int ZONES    = 4,
    parameter int DEBOUNCE = 8,
    parameter int SETTLE   = 16,
    parameter int MAX_RUN  = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    irrigation_sequencer_if.slave io
);
    localparam int ZW  = $clog2(ZONES);
    localparam int NB  = ZONES + 5;
    localparam int DCW = $clog2(DEBOUNCE + 1);
    localparam int SCW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_RUN,
        S_SETTLE,
        S_FAULT
    } state_t;

    logic [NB-1:0]  raw, sync1, sync2, deb;
    logic [DCW-1:0] db_cnt [NB];

    // Bit layout: 0 low, 1 mid, 2 high, 3.. earth, then air, then cold.
    assign raw = {io.low_temperature, io.air_humidity, io.earth_humidity,
                  io.high_water_level, io.mid_water_level, io.low_water_level};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DCW'(DEBOUNCE - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    logic             lvl_low, lvl_mid, lvl_high, air_wet, cold;
    logic             conflict, critical, fault, sprinkle_now;
    logic [ZONES-1:0] wet, eligible;

    assign lvl_low      = deb[0];
    assign lvl_mid      = deb[1];
    assign lvl_high     = deb[2];
    assign wet          = deb[3 +: ZONES];
    assign air_wet      = deb[ZONES+3];
    assign cold         = deb[ZONES+4];
    assign conflict     = (lvl_mid & ~lvl_low) | (lvl_high & ~lvl_mid);
    assign critical     = ~lvl_low & ~conflict;
    assign fault        = conflict | critical;
    assign sprinkle_now = ~air_wet & ~cold & lvl_mid;

`ifdef IRRIGATION_RUN_LIMIT_EN
    localparam int RCW = $clog2(MAX_RUN + 1);
    logic [RCW-1:0]   run_cnt, run_cnt_n;
    logic [ZONES-1:0] lockout, lockout_n;
`else
    logic [ZONES-1:0] lockout;
    assign lockout = '0;
`endif

    assign eligible = ~wet & ~lockout;

    state_t           state, state_n;
    logic [ZW-1:0]    last_served, last_n, zone_q, zone_n;
    logic             mode_q, mode_n;
    logic [SCW-1:0]   settle_cnt, settle_n;
    logic             found;
    logic [ZW-1:0]    pick;
    int               probe;

    // Round-robin search starts just past the last served zone, so the
    // current zone comes up last and is only re-served if nothing else is dry.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        probe = 0;
        for (int i = 1; i <= ZONES; i++) begin
            probe = (int'(last_served) + i) % ZONES;
            if (!found && eligible[ZW'(probe)]) begin
                found = 1'b1;
                pick  = ZW'(probe);
            end
        end
    end

    always_comb begin
        state_n  = state;
        last_n   = last_served;
        zone_n   = zone_q;
        mode_n   = mode_q;
        settle_n = settle_cnt;
`ifdef IRRIGATION_RUN_LIMIT_EN
        run_cnt_n = run_cnt;
        lockout_n = lockout & ~wet;
`endif
        case (state)
            S_IDLE: begin
                if (fault)              state_n = S_FAULT;
                else if (|eligible)     state_n = S_SCAN;
            end
            S_SCAN: begin
                if (fault) begin
                    state_n = S_FAULT;
                end else if (found) begin
                    state_n = S_RUN;
                    zone_n  = pick;
                    last_n  = pick;
                    mode_n  = sprinkle_now;
`ifdef IRRIGATION_RUN_LIMIT_EN
                    run_cnt_n = '0;
`endif
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RUN: begin
                if (fault) begin
                    state_n = S_FAULT;
                end else if (wet[zone_q]) begin
                    state_n  = S_SETTLE;
                    settle_n = '0;
                end
`ifdef IRRIGATION_RUN_LIMIT_EN
                else if (run_cnt == RCW'(MAX_RUN - 1)) begin
                    state_n            = S_SETTLE;
                    settle_n           = '0;
                    lockout_n[zone_q]  = 1'b1;
                end else begin
                    run_cnt_n = run_cnt + 1'b1;
                end
`endif
            end
            S_SETTLE: begin
                if (settle_cnt == SCW'(SETTLE - 1)) state_n  = S_IDLE;
                else                                settle_n = settle_cnt + 1'b1;
            end
            S_FAULT: begin
                if (!fault) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    logic [1:0]       fault_n;
    logic             refill_q, refill_n;
    logic [ZONES-1:0] zone_onehot;

    assign fault_n     = conflict ? 2'b10 : critical ? 2'b01 : (|lockout) ? 2'b11 : 2'b00;
    assign refill_n    = (lvl_high | conflict) ? 1'b0 : (~lvl_mid ? 1'b1 : refill_q);
    assign zone_onehot = {{(ZONES-1){1'b0}}, 1'b1} << zone_n;

    // Outputs are registered from the next state so the valves follow the
    // state change on the same edge rather than one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            last_served        <= ZW'(ZONES - 1);
            zone_q             <= '0;
            mode_q             <= 1'b0;
            settle_cnt         <= '0;
            refill_q           <= 1'b0;
            io.zone_valvule    <= '0;
            io.splinker_bomb   <= 1'b0;
            io.dripper_valvule <= 1'b0;
            io.active_zone     <= '0;
            io.fault_code      <= 2'b00;
            io.alarm           <= 1'b0;
`ifdef IRRIGATION_RUN_LIMIT_EN
            run_cnt            <= '0;
            lockout            <= '0;
`endif
        end else begin
            state              <= state_n;
            last_served        <= last_n;
            zone_q             <= zone_n;
            mode_q             <= mode_n;
            settle_cnt         <= settle_n;
            refill_q           <= refill_n;
            io.zone_valvule    <= (state_n == S_RUN) ? zone_onehot : '0;
            io.splinker_bomb   <= (state_n == S_RUN) && mode_n;
            io.dripper_valvule <= (state_n == S_RUN) && !mode_n;
            io.active_zone     <= zone_n;
            io.fault_code      <= fault_n;
            io.alarm           <= (fault_n != 2'b00);
`ifdef IRRIGATION_RUN_LIMIT_EN
            run_cnt            <= run_cnt_n;
            lockout            <= lockout_n;
`endif
        end
    end

    assign io.water_supply_valvule = refill_q;
endmodule

// File: tb/tb_irrigation_sequencer.sv
// Self-checking bench for irrigation_sequencer: a cycle model of the sequencing
// rules is compared every cycle, plus hand-computed literal checks per scenario.
module tb_irrigation_sequencer;
    localparam int ZONES    = 4;
    localparam int DEBOUNCE = 8;
    localparam int SETTLE   = 16;
    localparam int MAX_RUN  = 32;
    localparam int NB       = ZONES + 5;

    localparam int P_IDLE   = 0;
    localparam int P_SCAN   = 1;
    localparam int P_RUN    = 2;
    localparam int P_SETTLE = 3;
    localparam int P_FAULT  = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    irrigation_sequencer_if #(.ZONES(ZONES)) io ();

    irrigation_sequencer #(
        .ZONES(ZONES), .DEBOUNCE(DEBOUNCE), .SETTLE(SETTLE), .MAX_RUN(MAX_RUN)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .io     (io.slave)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cycleCount  = 0;

    logic [NB-1:0]    pipe0 = '0, pipe1 = '0, accepted = '0;
    int               streak [NB];
    int               phase = P_IDLE, curZone = 0, lastZone = ZONES - 1;
    int               settleLeft = 0, runLen = 0;
    bit               sprinkMode = 0;
    logic [ZONES-1:0] lockBits = '0;

    logic [ZONES-1:0] expZv = '0;
    logic             expSpr = 0, expDrip = 0, expRefill = 0, expAlarm = 0;
    logic [1:0]       expFc = 0;
    int               expAz = 0;

    task automatic modelReset();
        pipe0 = '0; pipe1 = '0; accepted = '0;
        for (int b = 0; b < NB; b++) streak[b] = 0;
        phase = P_IDLE; curZone = 0; lastZone = ZONES - 1;
        settleLeft = 0; runLen = 0; sprinkMode = 0; lockBits = '0;
        expZv = '0; expSpr = 0; expDrip = 0; expRefill = 0; expAlarm = 0;
        expFc = 0; expAz = 0;
    endtask

    task automatic modelStep();
        logic             low, mid, high, humid, chilly;
        logic [ZONES-1:0] wetNow, dryFree, newLock;
        logic [NB-1:0]    rawNow, sample;
        bit               conf, crit, bad, got;
        int               cand;
        low = accepted[0]; mid = accepted[1]; high = accepted[2];
        wetNow = accepted[3 +: ZONES];
        humid = accepted[ZONES+3]; chilly = accepted[ZONES+4];
        conf = (mid && !low) || (high && !mid);
        crit = !low && !conf;
        bad  = conf || crit;
        expFc    = conf ? 2'd2 : crit ? 2'd1 : (lockBits != 0) ? 2'd3 : 2'd0;
        expAlarm = (expFc != 0);
        if (high || conf)  expRefill = 0;
        else if (!mid)     expRefill = 1;
        dryFree = ~wetNow & ~lockBits;
        newLock = lockBits & ~wetNow;
        case (phase)
            P_IDLE:  if (bad) phase = P_FAULT; else if (dryFree != 0) phase = P_SCAN;
            P_SCAN: begin
                if (bad) phase = P_FAULT;
                else begin
                    got = 0;
                    for (int k = 1; k <= ZONES; k++) begin
                        cand = (lastZone + k) % ZONES;
                        if (!got && dryFree[cand]) begin got = 1; curZone = cand; end
                    end
                    if (got) begin
                        lastZone = curZone; runLen = 0; phase = P_RUN;
                        sprinkMode = !humid && !chilly && mid;
                    end else phase = P_IDLE;
                end
            end
            P_RUN: begin
                if (bad) phase = P_FAULT;
                else if (wetNow[curZone]) begin phase = P_SETTLE; settleLeft = SETTLE; end
`ifdef IRRIGATION_RUN_LIMIT_EN
                else begin
                    runLen++;
                    if (runLen == MAX_RUN) begin
                        newLock[curZone] = 1'b1; phase = P_SETTLE; settleLeft = SETTLE;
                    end
                end
`endif
            end
            P_SETTLE: begin
                settleLeft--;
                if (settleLeft == 0) phase = P_IDLE;
            end
            default: if (!bad) phase = P_IDLE;
        endcase
`ifdef IRRIGATION_RUN_LIMIT_EN
        lockBits = newLock;
`endif
        expZv   = (phase == P_RUN) ? ZONES'(1 << curZone) : '0;
        expSpr  = (phase == P_RUN) && sprinkMode;
        expDrip = (phase == P_RUN) && !sprinkMode;
        expAz   = curZone;
        // Sensors reach the debouncer two edges after they are applied.
        rawNow = {io.low_temperature, io.air_humidity, io.earth_humidity,
                  io.high_water_level, io.mid_water_level, io.low_water_level};
        sample = pipe1; pipe1 = pipe0; pipe0 = rawNow;
        for (int b = 0; b < NB; b++) begin
            if (sample[b] != accepted[b]) begin
                streak[b]++;
                if (streak[b] == DEBOUNCE) begin accepted[b] = sample[b]; streak[b] = 0; end
            end else streak[b] = 0;
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    always @(negedge clock) begin
        cycleCount++;
        if (reset_n) begin
            vectors++;
            if (io.zone_valvule !== expZv || io.splinker_bomb !== expSpr ||
                io.dripper_valvule !== expDrip || io.water_supply_valvule !== expRefill ||
                io.alarm !== expAlarm || io.fault_code !== expFc ||
                int'(io.active_zone) != expAz) begin
                miscompares++;
                $display("[TB] FAIL cycle %0d outputs: got zv=%b spr=%b drip=%b refill=%b alarm=%b fc=%b az=%0d, expected zv=%b spr=%b drip=%b refill=%b alarm=%b fc=%b az=%0d",
                         cycleCount, io.zone_valvule, io.splinker_bomb, io.dripper_valvule,
                         io.water_supply_valvule, io.alarm, io.fault_code, io.active_zone,
                         expZv, expSpr, expDrip, expRefill, expAlarm, expFc, expAz);
            end
        end
    end

    task automatic applyStimulus(input logic low, input logic mid, input logic high,
                                 input logic [ZONES-1:0] earth, input logic air, input logic cold);
        io.low_water_level  = low;
        io.mid_water_level  = mid;
        io.high_water_level = high;
        io.earth_humidity   = earth;
        io.air_humidity     = air;
        io.low_temperature  = cold;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int peek(input int sel);
        case (sel)
            0:       return int'(io.zone_valvule);
            1:       return int'(io.fault_code);
            default: return int'(io.water_supply_valvule);
        endcase
    endfunction

    // Waits on negedges until the selected output equals want; a timeout shows up as a failed check.
    task automatic waitFor(input string name, input int sel, input int want,
                           input int budget, output int cycles);
        cycles = 0;
        while (peek(sel) != want && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput(name, peek(sel), want);
    endtask

    initial begin
        int cyc, onCount;
        applyStimulus(1, 1, 0, 4'b1110, 0, 0);
        repeat (2) @(negedge clock);
        checkOutput("reset zone_valvule", int'(io.zone_valvule), 0);
        checkOutput("reset fault_code", int'(io.fault_code), 0);
        checkOutput("reset refill", int'(io.water_supply_valvule), 0);

        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("edge1 critical code", int'(io.fault_code), 1);
        checkOutput("edge1 refill open", int'(io.water_supply_valvule), 1);
        waitFor("first run zone0", 0, 4'b0001, 40, cyc);
        checkOutput("first run latency", cyc + 1, 2 + DEBOUNCE + 3);
        checkOutput("first run sprinkler", int'(io.splinker_bomb), 1);
        checkOutput("first run active_zone", int'(io.active_zone), 0);

        applyStimulus(1, 1, 0, 4'b0101, 1, 0);
        waitFor("rr zone1", 0, 4'b0010, 60, cyc);
        checkOutput("rr zone1 dripper", int'(io.dripper_valvule), 1);
        checkOutput("rr zone1 no sprinkler", int'(io.splinker_bomb), 0);
        applyStimulus(1, 1, 0, 4'b0111, 1, 0);
        waitFor("rr zone1 off", 0, 0, 20, cyc);
        checkOutput("wet to off latency", cyc, 2 + DEBOUNCE + 1);
        waitFor("rr zone3", 0, 4'b1000, 40, cyc);
        checkOutput("settle gap", cyc, SETTLE + 2);
        applyStimulus(1, 1, 0, 4'b1101, 1, 0);
        waitFor("rr wrap zone1", 0, 4'b0010, 60, cyc);
        checkOutput("rr wrap active_zone", int'(io.active_zone), 1);

        applyStimulus(0, 1, 0, 4'b1101, 1, 0);
        waitFor("conflict code", 1, 2, 30, cyc);
        checkOutput("conflict valves off", int'(io.zone_valvule), 0);
        checkOutput("conflict alarm", int'(io.alarm), 1);
        checkOutput("conflict refill off", int'(io.water_supply_valvule), 0);
        applyStimulus(1, 1, 0, 4'b1101, 1, 0);
        waitFor("conflict cleared", 1, 0, 30, cyc);
        waitFor("resume zone1", 0, 4'b0010, 20, cyc);

        applyStimulus(1, 0, 0, 4'b1111, 0, 0);
        waitFor("refill opens", 2, 1, 30, cyc);
        applyStimulus(1, 1, 0, 4'b1111, 0, 0);
        repeat (20) @(negedge clock);
        checkOutput("refill holds at mid", int'(io.water_supply_valvule), 1);
        applyStimulus(1, 1, 1, 4'b1111, 0, 0);
        waitFor("refill closes at high", 2, 0, 30, cyc);
        applyStimulus(1, 1, 0, 4'b1111, 0, 0);
        repeat (20) @(negedge clock);
        checkOutput("refill stays closed", int'(io.water_supply_valvule), 0);

        applyStimulus(1, 1, 0, 4'b1011, 0, 0);
        repeat (3) @(negedge clock);
        applyStimulus(1, 1, 0, 4'b1111, 0, 0);
        onCount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (io.zone_valvule != 0) onCount++;
        end
        checkOutput("glitch ignored", onCount, 0);

`ifdef IRRIGATION_RUN_LIMIT_EN
        applyStimulus(1, 1, 0, 4'b1110, 0, 0);
        waitFor("limit zone0 start", 0, 4'b0001, 60, cyc);
        onCount = 0;
        while (io.zone_valvule == 4'b0001 && onCount < MAX_RUN + 10) begin
            onCount++;
            @(negedge clock);
        end
        checkOutput("limit run length", onCount, MAX_RUN);
        waitFor("lockout code", 1, 3, 5, cyc);
        onCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (io.zone_valvule != 0) onCount++;
        end
        checkOutput("locked zone skipped", onCount, 0);
        applyStimulus(1, 1, 0, 4'b1111, 0, 0);
        waitFor("lockout cleared", 1, 0, 30, cyc);
        checkOutput("lockout alarm clear", int'(io.alarm), 0);
`endif

        applyStimulus(1, 1, 0, 4'b1011, 0, 0);
        waitFor("zone2 run", 0, 4'b0100, 60, cyc);
        checkOutput("zone2 sprinkler", int'(io.splinker_bomb), 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset valves", int'(io.zone_valvule), 0);
        checkOutput("async reset sprinkler", int'(io.splinker_bomb), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
